// File: rtl/wait_state_generator.sv
// ---------------------------------------------------------------------------
// wait_state_generator
//
// Generates the READY inputs of the CPU and of the DMA controller. It watches
// the arbitrated ISA command strobes and the current bus owner, and inserts a
// programmable number of wait states into every bus cycle. A cycle is also
// stretched while the expansion bus holds I/O CH RDY low. If a cycle sits in
// WAIT too long, it is force-completed and bus_timeout pulses for one clock.
//
// All flops run on `clock`. The processor clock `cpu_clock` is treated as a
// sampled data signal, and its edges are recovered internally:
//   - the FSM advances on cpu_clock rising edges;
//   - the READY outputs change only on cpu_clock falling edges, as an
//     8284-style clock generator would drive them.
//
// Ports
//   clock              in   system clock, rising-edge
//   reset              in   asynchronous, active-high reset
//   cpu_clock          in   processor clock (sampled)
//   address_enable_n   in   bus owner: 0 = CPU, 1 = DMA/external master
//   dma_acknowledge_n  in   [3:0] active-low DACK per DMA channel
//   io_read_n          in   arbitrated I/O read strobe
//   io_write_n         in   arbitrated I/O write strobe
//   memory_read_n      in   arbitrated memory read strobe
//   memory_write_n     in   arbitrated memory write strobe
//   io_channel_ready   in   asynchronous I/O CH RDY; 0 stretches the cycle
//   processor_ready    out  READY to the CPU; 0 inserts a wait state
//   dma_ready          out  READY to the DMA controller
//   bus_timeout        out  one-clock pulse on a forced completion
// ---------------------------------------------------------------------------
module wait_state_generator #(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned DMA_WAIT_STATES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_clock,
    input  logic       address_enable_n,
    input  logic [3:0] dma_acknowledge_n,
    input  logic       io_read_n,
    input  logic       io_write_n,
    input  logic       memory_read_n,
    input  logic       memory_write_n,
    input  logic       io_channel_ready,
    output logic       processor_ready,
    output logic       dma_ready,
    output logic       bus_timeout
);

    localparam logic [3:0] IO_WS      = 4'(IO_WAIT_STATES);
    localparam logic [3:0] MEM_WS     = 4'(MEM_WAIT_STATES);
    localparam logic [3:0] DMA_WS     = 4'(DMA_WAIT_STATES);
    localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT_CYCLES);
    localparam bit         TO_ENABLED = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clock-domain front end
    logic   prev_cpu_clock_q;
    logic   rdy_meta_q;
    logic   rdy_sync_q;

    // FSM and registered outputs
    state_t state_q;
    logic   owner_dma_q;
    logic [3:0] ws_cnt_q;
    logic [7:0] to_cnt_q;
    logic   processor_ready_q;
    logic   dma_ready_q;
    logic   bus_timeout_q;

    // Combinational decode
    logic       cpu_clock_posedge;
    logic       cpu_clock_negedge;
    logic       io_cmd;
    logic       mem_cmd;
    logic       cmd_active;
    logic       dma_cycle;
    logic       cpu_cycle;
    logic       owned_cycle;
    logic [3:0] ws_load;
    logic       need_wait;
    logic [3:0] ws_cnt_d;
    logic [7:0] to_cnt_d;
    logic       timeout_hit;
    logic       hold;
    logic       owner;

    // ---- cpu_clock edge recovery and I/O CH RDY synchroniser ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_cpu_clock_q <= 1'b0;
            rdy_meta_q       <= 1'b1;
            rdy_sync_q       <= 1'b1;
        end else begin
            prev_cpu_clock_q <= cpu_clock;
            rdy_meta_q       <= io_channel_ready;
            rdy_sync_q       <= rdy_meta_q;
        end
    end

    assign cpu_clock_posedge = ~prev_cpu_clock_q &  cpu_clock;
    assign cpu_clock_negedge =  prev_cpu_clock_q & ~cpu_clock;

    // ---- command and ownership decode ----
    assign io_cmd     = ~io_read_n | ~io_write_n;
    assign mem_cmd    = ~memory_read_n | ~memory_write_n;
    assign cmd_active = io_cmd | mem_cmd;
    assign dma_cycle  = address_enable_n & ~(&dma_acknowledge_n);
    assign cpu_cycle  = ~address_enable_n;
    // An external master (AEN high with no DACK) gets no wait states at all.
    assign owned_cycle = cpu_cycle | dma_cycle;

    // DMA overrides the command type; I/O wins over memory if both are present.
    always_comb begin
        ws_load = MEM_WS;
        if (dma_cycle) begin
            ws_load = DMA_WS;
        end else if (io_cmd) begin
            ws_load = IO_WS;
        end
    end

    assign need_wait = (ws_load != 4'd0) | ~rdy_sync_q;

    assign ws_cnt_d    = (ws_cnt_q != 4'd0) ? (ws_cnt_q - 4'd1) : 4'd0;
    assign to_cnt_d    = (to_cnt_q == 8'hFF) ? 8'hFF : (to_cnt_q + 8'd1);
    assign timeout_hit = TO_ENABLED && (to_cnt_d == TO_LIMIT);

    // In IDLE, ready is pulled low before the FSM moves, so the very first
    // falling edge after a command already shows the wait. The owner is the
    // live bus owner in IDLE; later it is the owner latched at cycle start.
    assign hold  = (state_q == ST_WAIT) |
                   ((state_q == ST_IDLE) & cmd_active & owned_cycle & need_wait);
    assign owner = (state_q == ST_IDLE) ? dma_cycle : owner_dma_q;

    // ---- cycle FSM (cpu_clock rising) and READY outputs (cpu_clock falling) ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            owner_dma_q       <= 1'b0;
            ws_cnt_q          <= 4'd0;
            to_cnt_q          <= 8'd0;
            processor_ready_q <= 1'b1;
            dma_ready_q       <= 1'b1;
            bus_timeout_q     <= 1'b0;
        end else begin
            bus_timeout_q <= 1'b0;

            if (cpu_clock_posedge) begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_active && owned_cycle) begin
                            owner_dma_q <= dma_cycle;
                            ws_cnt_q    <= ws_load;
                            to_cnt_q    <= 8'd0;
                            state_q     <= need_wait ? ST_WAIT : ST_DONE;
                        end
                    end
                    ST_WAIT: begin
                        ws_cnt_q <= ws_cnt_d;
                        to_cnt_q <= to_cnt_d;
                        if (!cmd_active) begin
                            // Command withdrawn mid-cycle: abandon the wait.
                            state_q <= ST_IDLE;
                        end else if (timeout_hit) begin
                            // A stuck I/O CH RDY must not hang the bus forever.
                            state_q       <= ST_DONE;
                            bus_timeout_q <= 1'b1;
                        end else if ((ws_cnt_d == 4'd0) && rdy_sync_q) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (!cmd_active) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end

            if (cpu_clock_negedge) begin
                processor_ready_q <= ~(hold & ~owner);
                dma_ready_q       <= ~(hold &  owner);
            end
        end
    end

    assign processor_ready = processor_ready_q;
    assign dma_ready       = dma_ready_q;
    assign bus_timeout     = bus_timeout_q;

endmodule
